// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared types and constants for the ADC capture sequencer:
//               state encoding, default sample width and pair packing order.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    // Default width of one ADC channel sample (two's complement)
    localparam int c_data_w_dflt = 12;

    // Output pair packing: 1 selects {b, a} (channel B in the upper half)
    localparam bit c_pack_b_high = 1'b1;

    // Capture sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_FLUSH   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_win_accum.sv
`default_nettype none
// ============================================================================
// Module      : adc_win_accum
// Description : Per-channel window reducer. The window counter lives in the
//               parent; this block only sees first/last-of-window strobes.
//               With ADC_CAPTURE_AVG_EN defined it produces the floor mean of
//               the window one cycle after the window closes; otherwise it
//               returns the first sample of the window with no added latency.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_win_accum #(
    parameter int DATA_W = 12,
    parameter int DEC_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              win_first,
    input  logic              win_last,
    input  logic [DEC_W-1:0]  shift,
    input  logic [DATA_W-1:0] sample,
    output logic              beat_valid,
    output logic [DATA_W-1:0] beat_data
);

`ifdef ADC_CAPTURE_AVG_EN
    // Enough headroom for 2^(2^DEC_W - 1) samples of DATA_W bits
    localparam int ACC_W = DATA_W + (1 << DEC_W) - 1;

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     r_valid;
    logic        [DATA_W-1:0] r_mean;

    // Running sum restarts on the first sample of each window
    always_comb begin
        w_sum = (win_first ? ACC_W'(0) : r_acc) + ACC_W'(signed'(sample));
    end

    // Accumulate, and register the arithmetic-shift mean when the window closes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_mean  <= '0;
        end else begin
            r_valid <= en & win_last;
            if (en) begin
                r_acc <= w_sum;
            end
            if (en & win_last) begin
                r_mean <= DATA_W'(w_sum >>> shift);
            end
        end
    end

    assign beat_valid = r_valid;
    assign beat_data  = r_mean;
`else
    logic [DATA_W-1:0] r_first;
    logic              w_unused_shift;

    // The window length does not affect plain decimation
    assign w_unused_shift = ^shift;

    // Hold the first sample of each window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_first <= '0;
        end else if (en & win_first) begin
            r_first <= sample;
        end
    end

    // A one-sample window must forward the live sample, not the stale register
    assign beat_valid = en & win_last;
    assign beat_data  = win_first ? sample : r_first;
`endif

endmodule
`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_capture_ctrl
// Description : Arm / trigger / delay / capture sequencer for the dual-channel
//               ADC stream. Emits a programmed number of decimated {b, a}
//               sample pairs through a single-entry valid/ready register.
//               Build option: ADC_CAPTURE_AVG_EN selects window averaging
//               (one extra cycle of beat latency) instead of first-sample
//               decimation.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_ctrl
    import adc_pkg::*;
#(
    parameter int DATA_W = c_data_w_dflt,
    parameter int LEN_W  = 16,
    parameter int DEC_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                abort,
    input  logic                trig,
    input  logic [LEN_W-1:0]    cfg_delay,
    input  logic [LEN_W-1:0]    cfg_length,
    input  logic [DEC_W-1:0]    cfg_decim,
    input  logic [DATA_W-1:0]   a_data,
    input  logic [DATA_W-1:0]   b_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [2*DATA_W-1:0] m_data,
    output logic                m_last,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    // Window counter must reach 2^(2^DEC_W - 1) - 1
    localparam int WIN_W = (1 << DEC_W) - 1;
    localparam logic [WIN_W-1:0] c_win_ones = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_trig_d;
    logic                w_trig_edge;
    logic [LEN_W-1:0]    r_delay;
    logic [LEN_W-1:0]    r_length;
    logic [DEC_W-1:0]    r_decim;
    logic [LEN_W-1:0]    r_dly_cnt;
    logic [LEN_W-1:0]    r_beat_cnt;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [WIN_W-1:0]    w_win_mask;
    logic                w_win_first;
    logic                w_win_last;
    logic                w_capturing;
    logic                w_beat_valid;
    logic                w_unused_valid_b;
    logic [DATA_W-1:0]   w_beat_a;
    logic [DATA_W-1:0]   w_beat_b;
    logic [2*DATA_W-1:0] w_pair;
    logic                w_beat_evt;
    logic                w_beat_final;
    logic                w_hs;
    logic                w_load_ok;
    logic                w_arm_ok;
    logic                w_busy;
    logic                w_done_set;
    logic                r_valid;
    logic                r_last;
    logic [2*DATA_W-1:0] r_data;
    logic                r_done;
    logic                r_overflow;

    assign w_trig_edge  = trig & ~r_trig_d;
    assign w_win_mask   = c_win_ones >> (WIN_W - int'(r_decim));
    assign w_win_first  = (r_win_cnt == '0);
    assign w_win_last   = (r_win_cnt == w_win_mask);
    assign w_capturing  = (r_state == ST_CAPTURE);
    assign w_beat_evt   = w_capturing & w_beat_valid;
    assign w_beat_final = w_beat_evt & (r_beat_cnt == (r_length - LEN_W'(1)));
    assign w_hs         = r_valid & m_ready;
    assign w_load_ok    = ~r_valid | m_ready;
    assign w_arm_ok     = (r_state == ST_IDLE) & arm & ~abort;
    assign w_pair       = c_pack_b_high ? {w_beat_b, w_beat_a} : {w_beat_a, w_beat_b};

    adc_win_accum #(
        .DATA_W (DATA_W),
        .DEC_W  (DEC_W)
    ) u_accum_a (
        .clk        (clk),
        .rst        (rst),
        .en         (w_capturing),
        .win_first  (w_win_first),
        .win_last   (w_win_last),
        .shift      (r_decim),
        .sample     (a_data),
        .beat_valid (w_beat_valid),
        .beat_data  (w_beat_a)
    );

    adc_win_accum #(
        .DATA_W (DATA_W),
        .DEC_W  (DEC_W)
    ) u_accum_b (
        .clk        (clk),
        .rst        (rst),
        .en         (w_capturing),
        .win_first  (w_win_first),
        .win_last   (w_win_last),
        .shift      (r_decim),
        .sample     (b_data),
        .beat_valid (w_unused_valid_b),
        .beat_data  (w_beat_b)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; abort overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (arm) begin
                    w_state_nxt = (cfg_length == '0) ? ST_IDLE : ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_trig_edge) begin
                    w_state_nxt = (r_delay == '0) ? ST_CAPTURE : ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (r_dly_cnt == '0) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_beat_final) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // State-derived outputs: busy level and the completion strobe request
    always_comb begin
        w_busy     = (r_state != ST_IDLE);
        w_done_set = 1'b0;
        if (w_arm_ok && (cfg_length == '0)) begin
            w_done_set = 1'b1;
        end
        if (!abort && (r_state == ST_FLUSH) && w_hs) begin
            w_done_set = 1'b1;
        end
    end

    // Trigger history, configuration latch and delay/window/beat counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_trig_d   <= 1'b0;
            r_delay    <= '0;
            r_length   <= '0;
            r_decim    <= '0;
            r_dly_cnt  <= '0;
            r_beat_cnt <= '0;
            r_win_cnt  <= '0;
        end else begin
            r_trig_d <= trig;
            if (w_arm_ok) begin
                r_delay    <= cfg_delay;
                r_length   <= cfg_length;
                r_decim    <= cfg_decim;
                r_beat_cnt <= '0;
            end
            if ((r_state == ST_ARMED) && w_trig_edge) begin
                r_dly_cnt <= r_delay - LEN_W'(1);
            end else if (r_state == ST_DELAY) begin
                r_dly_cnt <= r_dly_cnt - LEN_W'(1);
            end
            if (w_capturing) begin
                r_win_cnt <= w_win_last ? '0 : r_win_cnt + WIN_W'(1);
            end else begin
                r_win_cnt <= '0;
            end
            if (w_beat_evt) begin
                r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
        end
    end

    // Single-entry output register with drop detection and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_arm_ok) begin
                r_overflow <= 1'b0;
            end
            if (abort) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_beat_evt) begin
                if (w_load_ok) begin
                    r_valid <= 1'b1;
                    r_data  <= w_pair;
                    r_last  <= w_beat_final;
                end else begin
                    // Held beat stays put; if the dropped beat was the final
                    // one, the held beat becomes the end of the capture
                    r_overflow <= 1'b1;
                    if (w_beat_final) begin
                        r_last <= 1'b1;
                    end
                end
            end else if (w_hs) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign m_valid  = r_valid;
    assign m_last   = r_last;
    assign m_data   = r_data;
    assign busy     = w_busy;
    assign done     = r_done;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
